// File: rtl/alu_uart_pkg.sv
// Shared UART-side definitions: sequencer state encoding and ASCII constants
// used by both the TX sequencer and the RX parser.
package alu_uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NSTATES = 7;

    // One-hot state encoding for the result TX sequencer
    typedef enum logic [NSTATES-1:0] {
        ST_IDLE  = 7'b000_0001,
        ST_SKIP  = 7'b000_0010,
        ST_LOAD  = 7'b000_0100,
        ST_WAIT  = 7'b000_1000,
        ST_TERM  = 7'b001_0000,
        ST_TWAIT = 7'b010_0000,
        ST_FIN   = 7'b100_0000
    } state_e;

    localparam logic [BYTE_W-1:0] CHAR_0     = 8'h30;
    localparam logic [BYTE_W-1:0] CHAR_A     = 8'h41;
    localparam logic [BYTE_W-1:0] CHAR_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] CHAR_LF    = 8'h0A;

endpackage

// File: rtl/alu_result_tx_sequencer_if.sv
// Handshake bundle between the command FSM / ALU, the result TX sequencer and the UART TX.
interface alu_result_tx_sequencer_if #(
    parameter int unsigned NDIGITS = 8
);
    logic                   start;
    logic [4*NDIGITS-1:0]   result;
    logic                   tx_done;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   busy;
    logic                   done;

    modport master (
        output start, result, tx_done,
        input  tx_data, tx_start, busy, done
    );

    modport slave (
        input  start, result, tx_done,
        output tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module hex_nibble_to_ascii
    import alu_uart_pkg::*;
(
    input  logic [3:0]        nibble,
    output logic [BYTE_W-1:0] ascii_c
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii_c = CHAR_0 + 8'(nibble);
        end else begin
            ascii_c = CHAR_A + 8'(nibble - 4'd10);
        end
    end

endmodule

// File: rtl/alu_result_tx_sequencer.sv
// Sends the latched ALU result to the UART TX as ASCII hex, MSB first,
// with optional leading-zero suppression and terminator byte.
module alu_result_tx_sequencer
    import alu_uart_pkg::*;
#(
    parameter int unsigned          NDIGITS        = 8,
    parameter bit                   SUPPRESS_ZEROS = 1'b1,
    parameter bit                   TERM_EN        = 1'b1,
    parameter logic [BYTE_W-1:0]    TERM_CHAR      = 8'h0A
) (
    input  logic                        clk,
    input  logic                        reset,
    alu_result_tx_sequencer_if.slave    bus
);

    localparam int unsigned RES_W = 4 * NDIGITS;
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

    state_e              state, state_nxt;
    logic [RES_W-1:0]    sh, sh_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_nxt;
    logic                tx_start_q, tx_start_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                tx_done_q;
    logic                txd_rise;
    logic [BYTE_W-1:0]   top_ascii_c;

    hex_nibble_to_ascii u_hex (
        .nibble  (sh[RES_W-1 -: 4]),
        .ascii_c (top_ascii_c)
    );

    // A level held high on tx_done counts as a single completion
    assign txd_rise = bus.tx_done & ~tx_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh         <= '0;
            idx        <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            sh         <= sh_nxt;
            idx        <= idx_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_start_q <= tx_start_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            tx_done_q  <= bus.tx_done;
        end
    end

    always_comb begin
        state_nxt    = state;
        sh_nxt       = sh;
        idx_nxt      = idx;
        tx_data_nxt  = tx_data_q;
        tx_start_nxt = 1'b0;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    sh_nxt    = bus.result;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = SUPPRESS_ZEROS ? ST_SKIP : ST_LOAD;
                end
            end
            ST_SKIP: begin
                // The last digit is always sent, so a zero result still yields '0'
                if ((sh[RES_W-1 -: 4] == 4'h0) && (idx < IDX_LAST)) begin
                    sh_nxt  = sh << 4;
                    idx_nxt = idx + 1'b1;
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_nxt  = top_ascii_c;
                tx_start_nxt = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (txd_rise) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = TERM_EN ? ST_TERM : ST_FIN;
                    end else begin
                        sh_nxt    = sh << 4;
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_TERM: begin
                tx_data_nxt  = TERM_CHAR;
                tx_start_nxt = 1'b1;
                state_nxt    = ST_TWAIT;
            end
            ST_TWAIT: begin
                if (txd_rise) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
